// File: rtl/float_addsub_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_addsub_seq_pkg
// Description : Shared definitions for the 16-bit team float units.
//               Float layout is sign[15], exp[14:7] (bias 127), man[6:0] with
//               a hidden leading 1. Exp 0 means zero and exp 255 means infinity.
//               Also holds the add/sub FSM state encodings and field helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package float_addsub_seq_pkg;

    // Float field layout
    localparam int c_width     = 16;
    localparam int c_sign_bit  = 15;
    localparam int c_exp_msb   = 14;
    localparam int c_exp_lsb   = 7;
    localparam int c_man_msb   = 6;
    localparam int c_exp_bias  = 127;
    localparam logic [7:0] c_exp_inf = 8'hFF;

    // Datapath widths: {1, man, 3 guard zeros}, one carry bit, signed exp
    localparam int c_sig_w  = 11;
    localparam int c_sum_w  = 12;
    localparam int c_lz_w   = 4;
    localparam int c_expn_w = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] f_exp(input logic [c_width-1:0] x);
        return x[c_exp_msb:c_exp_lsb];
    endfunction

    function automatic logic [6:0] f_man(input logic [c_width-1:0] x);
        return x[c_man_msb:0];
    endfunction

    function automatic logic f_is_inf(input logic [c_width-1:0] x);
        return (x[c_exp_msb:c_exp_lsb] == c_exp_inf);
    endfunction

    function automatic logic f_is_zero(input logic [c_width-1:0] x);
        return (x[c_exp_msb:c_exp_lsb] == 8'h00);
    endfunction

    function automatic logic [c_width-1:0] f_inf(input logic sign);
        return {sign, c_exp_inf, 7'h00};
    endfunction

    // Unbiased exponent, for units that need the true power of two
    function automatic int f_unbiased_exp(input logic [c_width-1:0] x);
        return int'(x[c_exp_msb:c_exp_lsb]) - c_exp_bias;
    endfunction

endpackage : float_addsub_seq_pkg
`default_nettype wire

// File: rtl/clz12.sv
`default_nettype none
// ============================================================================
// Module      : clz12
// Description : Combinational leading-zero count of a 12-bit value, counted
//               from bit 11. An all-zero input returns 12.
// Ports       : value [11:0] in  - word to scan
//               count [3:0]  out - number of zeros above the leading 1
// Revision    : 1.0 - initial release
// ============================================================================
module clz12 (
    input  logic [11:0] value,
    output logic [3:0]  count
);

    // Scan upward so the highest set bit wins
    always_comb begin
        count = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (value[i]) begin
                count = 4'(11 - i);
            end
        end
    end

endmodule : clz12
`default_nettype wire

// File: rtl/float_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : float_addsub_seq
// Description : Multi-cycle add/subtract of two 16-bit team floats. The FSM
//               steps IDLE -> ALIGN -> ADD -> NORM -> DONE with a fixed
//               latency. Rounding is by truncation. Exp 0 counts as zero and
//               exp 255 counts as infinity.
// Ports       : clk   in   rising-edge clock
//               reset in   synchronous active-high reset
//               start in   request, accepted in IDLE or DONE
//               sub   in   0 = a+b, 1 = a-b
//               a, b  in   16-bit operands
//               busy  out  high in ALIGN/ADD/NORM
//               done  out  one-cycle pulse, out valid
//               out   out  result, held until the next completion
// Revision    : 1.0 - initial release
// ============================================================================
module float_addsub_seq
    import float_addsub_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    state_t r_state;
    logic   r_busy;
    logic   r_done;
    logic [15:0] r_out;

    // Operands captured at accept; r_b already has the effective sign
    logic [15:0] r_a;
    logic [15:0] r_b;

    // ALIGN stage results
    logic               r_special;
    logic [15:0]        r_special_val;
    logic               r_sign;
    logic               r_eff_sub;
    logic [7:0]         r_exp_big;
    logic [c_sig_w-1:0] r_sig_big;
    logic [c_sig_w-1:0] r_sig_small;

    // ADD stage result
    logic [c_sum_w-1:0] r_sum;

    // ------------------------------------------------------------------
    // ALIGN: order by magnitude and shift the smaller significand
    // ------------------------------------------------------------------
    logic               w_a_big;
    logic [15:0]        w_big;
    logic [15:0]        w_small;
    logic [7:0]         w_shamt;
    logic [c_sig_w-1:0] w_sig_small_full;
    logic [c_sig_w-1:0] w_sig_small;
    logic               w_special;
    logic [15:0]        w_special_val;

    // Exp sits above man, so the low 15 bits compare as a magnitude
    assign w_a_big          = (r_a[14:0] >= r_b[14:0]);
    assign w_big            = w_a_big ? r_a : r_b;
    assign w_small          = w_a_big ? r_b : r_a;
    assign w_shamt          = f_exp(w_big) - f_exp(w_small);
    assign w_sig_small_full = {1'b1, f_man(w_small), 3'b000};
    assign w_sig_small      = (w_shamt >= 8'd11) ? '0 : (w_sig_small_full >> w_shamt);

    // Infinity outranks zero, and a outranks b
    always_comb begin
        w_special     = 1'b1;
        w_special_val = 16'h0000;
        if (f_is_inf(r_a)) begin
            w_special_val = f_inf(r_a[c_sign_bit]);
        end else if (f_is_inf(r_b)) begin
            w_special_val = f_inf(r_b[c_sign_bit]);
        end else if (f_is_zero(r_a) && f_is_zero(r_b)) begin
            w_special_val = 16'h0000;
        end else if (f_is_zero(r_a)) begin
            w_special_val = r_b;
        end else if (f_is_zero(r_b)) begin
            w_special_val = r_a;
        end else begin
            w_special = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // ADD: big >= small always holds, so the difference never goes negative
    // ------------------------------------------------------------------
    logic [c_sum_w-1:0] w_sum;

    assign w_sum = r_eff_sub ? ({1'b0, r_sig_big} - {1'b0, r_sig_small})
                             : ({1'b0, r_sig_big} + {1'b0, r_sig_small});

    // ------------------------------------------------------------------
    // NORM: the leading 1 belongs at bit 10. Shift left by the count of
    // zeros above bit 11 and adjust exp by 1 - count. This covers the
    // carry-out case (count 0 gives exp+1) and the cancellation case alike.
    // ------------------------------------------------------------------
    logic [c_lz_w-1:0]          w_lzc;
    logic [c_sum_w-1:0]         w_norm;
    logic [6:0]                 w_man;
    logic signed [c_expn_w-1:0] w_exp_norm;
    logic [15:0]                w_result;
    logic [4:0]                 w_unused_norm;

    clz12 u_clz12 (
        .value (r_sum),
        .count (w_lzc)
    );

    assign w_norm        = r_sum << w_lzc;
    assign w_man         = w_norm[10:4];
    assign w_unused_norm = {w_norm[11], w_norm[3:0]};
    assign w_exp_norm    = $signed({2'b00, r_exp_big}) + 10'sd1
                         - $signed({6'b000000, w_lzc});

    always_comb begin
        w_result = {r_sign, w_exp_norm[7:0], w_man};
        if (r_special) begin
            w_result = r_special_val;
        end else if (r_sum == '0) begin
            w_result = 16'h0000;
        end else if (w_exp_norm >= 10'sd255) begin
            w_result = f_inf(r_sign);
        end else if (w_exp_norm <= 10'sd0) begin
            w_result = 16'h0000;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_ALIGN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ALIGN: r_state <= ST_ADD;
                ST_ADD:   r_state <= ST_NORM;
                ST_NORM: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_out   <= w_result;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers load only in their own stage, so nothing needs reset
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
            r_a <= a;
            r_b <= {b[c_sign_bit] ^ sub, b[14:0]};
        end
        if (r_state == ST_ALIGN) begin
            r_special     <= w_special;
            r_special_val <= w_special_val;
            r_sign        <= w_big[c_sign_bit];
            r_eff_sub     <= r_a[c_sign_bit] ^ r_b[c_sign_bit];
            r_exp_big     <= f_exp(w_big);
            r_sig_big     <= {1'b1, f_man(w_big), 3'b000};
            r_sig_small   <= w_sig_small;
        end
        if (r_state == ST_ADD) begin
            r_sum <= w_sum;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule : float_addsub_seq
`default_nettype wire

// File: tb/tb_float_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_addsub_seq
// Description : Self-checking bench for float_addsub_seq. Expected results
//               go into a scoreboard queue when an operation is issued and
//               are popped when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_addsub_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int n_cmp;
    int n_err;
    logic [15:0] sb_q[$];

    float_addsub_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic [15:0] exp_out);
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        sb_q.push_back(exp_out);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat counts edges from the accepting edge (inclusive) to done
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out got %h want 0000", out); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        logic [15:0] expv;
        issue(16'h3F80, 16'h4000, 1'b0, 16'h4040);
        // after accept edge and the two following edges the unit is busy
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL basic_busy cyc%0d got busy=%b done=%b want busy=1 done=0", k, busy, done);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_cycle got busy=%b done=%b want busy=0 done=1", busy, done);
        end
        if (done === 1'b1) begin
            expv = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            n_cmp++;
            if (out !== expv) begin n_err++; $display("FAIL basic_out got %h want %h", out, expv); end
        end else begin
            sb_q.delete();
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL basic_single_pulse got done=%b want 0", done); end
    endtask

    typedef struct packed {
        logic [15:0] ta;
        logic [15:0] tb;
        logic        tsub;
        logic [15:0] texp;
    } vec_t;

    task automatic test_arith;
        vec_t vecs[15];
        int lat;
        logic [15:0] expv;
        vecs[0]  = '{16'h4040, 16'h4040, 1'b1, 16'h0000}; // exact cancel
        vecs[1]  = '{16'h3F80, 16'h4000, 1'b1, 16'hBF80}; // 1 - 2
        vecs[2]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80}; // overflow
        vecs[3]  = '{16'h0000, 16'h3FC0, 1'b1, 16'hBFC0}; // zero a
        vecs[4]  = '{16'h3FC0, 16'h8000, 1'b1, 16'h3FC0}; // zero b
        vecs[5]  = '{16'h8000, 16'h0000, 1'b0, 16'h0000}; // both zero
        vecs[6]  = '{16'h0055, 16'h3F80, 1'b0, 16'h3F80}; // exp0 with man bits
        vecs[7]  = '{16'h7F80, 16'h3F80, 1'b0, 16'h7F80}; // a inf
        vecs[8]  = '{16'h3F80, 16'h7F80, 1'b1, 16'hFF80}; // b inf, flipped
        vecs[9]  = '{16'hFF80, 16'h7F80, 1'b0, 16'hFF80}; // a inf priority
        vecs[10] = '{16'h0080, 16'h00C0, 1'b1, 16'h0000}; // underflow flush
        vecs[11] = '{16'h4000, 16'h3380, 1'b0, 16'h4000}; // shift >= 11
        vecs[12] = '{16'h3F80, 16'h3C00, 1'b0, 16'h3F81}; // shift 7 keeps lsb
        vecs[13] = '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80}; // shift 8 truncates
        vecs[14] = '{16'h3F80, 16'hC000, 1'b0, 16'hBF80}; // 1 + -2
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].ta, vecs[i].tb, vecs[i].tsub, vecs[i].texp);
            wait_done(lat);
            n_cmp++;
            if (lat != 4) begin n_err++; $display("FAIL arith%0d_latency got %0d want 4", i, lat); end
            if (done === 1'b1) begin
                expv = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                n_cmp++;
                if (out !== expv) begin
                    n_err++;
                    $display("FAIL arith%0d_out a=%h b=%h sub=%b got %h want %h",
                             i, vecs[i].ta, vecs[i].tb, vecs[i].tsub, out, expv);
                end
            end else begin
                sb_q.delete();
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [15:0] expv;
        issue(16'h3F80, 16'h4000, 1'b0, 16'h4040);
        wait_done(lat);
        n_cmp++;
        if (done !== 1'b1 || out !== 16'h4040) begin
            n_err++;
            $display("FAIL b2b_first got done=%b out=%h want done=1 out=4040", done, out);
        end
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        // start raised in the DONE cycle itself
        issue(16'h3F00, 16'h3F00, 1'b0, 16'h3F80);
        wait_done(lat);
        n_cmp++;
        if (lat != 4) begin n_err++; $display("FAIL b2b_latency got %0d want 4", lat); end
        if (done === 1'b1) begin
            expv = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            n_cmp++;
            if (out !== expv) begin n_err++; $display("FAIL b2b_out got %h want %h", out, expv); end
        end else begin
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore;
        int pulses;
        logic [15:0] seen;
        logic [15:0] expv;
        pulses = 0;
        seen   = 16'h0000;
        issue(16'h3F80, 16'h3F80, 1'b0, 16'h4000);
        @(posedge clk);
        #1;
        // busy now: new request and changed operands must be ignored
        a     = 16'h4040;
        b     = 16'h4040;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) begin
                pulses++;
                seen = out;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL busy_ignore_pulses got %0d want 1", pulses); end
        expv = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        n_cmp++;
        if (seen !== expv) begin n_err++; $display("FAIL busy_ignore_out got %h want %h", seen, expv); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        int lat;
        logic [15:0] expv;
        pulses = 0;
        issue(16'h3F80, 16'h4000, 1'b0, 16'h4040);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        // state is NORM here
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_mid_state got busy=%b done=%b out=%h want 0 0 0000", busy, done, out);
        end
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL reset_mid_pulses got %0d want 0", pulses); end
        issue(16'h3F80, 16'h3F80, 1'b0, 16'h4000);
        wait_done(lat);
        n_cmp++;
        if (lat != 4) begin n_err++; $display("FAIL after_reset_latency got %0d want 4", lat); end
        if (done === 1'b1) begin
            expv = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            n_cmp++;
            if (out !== expv) begin n_err++; $display("FAIL after_reset_out got %h want %h", out, expv); end
        end else begin
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_priority;
        int pulses;
        pulses = 0;
        a     = 16'h3F80;
        b     = 16'h3F80;
        sub   = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_prio_busy got %b want 0", busy); end
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL reset_prio_pulses got %0d want 0", pulses); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_arith;
        test_back_to_back;
        test_busy_ignore;
        test_reset_mid;
        test_reset_priority;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case a task stalls
    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule : tb_float_addsub_seq
`default_nettype wire
